// File: rtl/fifo_pkg.sv
// Shared constants and types for the dual-clock FIFO and its read-side drain stage.
package fifo_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 64;

  // Occupancy of the two-entry drain buffer: 0, 1 or 2 words.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/skid buffer feeding a registered valid/ready stream.
// The head register always holds the oldest word and drives m_data/m_valid directly.
module stream_skid_buf #(
  parameter int W = fifo_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head_d, head_q;
  logic [W-1:0] skid_d, skid_q;
  logic         head_vld_d, head_vld_q;
  logic         skid_vld_d, skid_vld_q;
  logic         drain;

  assign drain = head_vld_q && m_ready;

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latch).
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = push;
        if (push) skid_d = push_data;
      end else begin
        head_vld_d = push;
        if (push) head_d = push_data;
      end
    end else if (push) begin
      // The pop rule never pushes into a full buffer, so a non-empty head means the skid is free.
      if (!head_vld_q) begin
        head_d     = push_data;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = push_data;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // NOTE: skid data is only observed behind skid_vld_q, so it needs no reset; head data is
  // reset because it is m_data, which must read zero out of reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign m_valid = head_vld_q;
  assign m_data  = head_q;
  assign occ     = fifo_pkg::occ_t'(head_vld_q) + fifo_pkg::occ_t'(skid_vld_q);

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the FIFO into a 2-entry buffer and presents a framed
// valid/ready stream with a per-frame last flag and a frame-done pulse.
module fifo_rd_stream #(
  parameter  int DATA_W    = fifo_pkg::DATA_W,
  parameter  int FRAME_LEN = fifo_pkg::FRAME_LEN,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              frame_done,
  output logic [1:0]        occ
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] beat_d, beat_q;
  logic             frame_done_d, frame_done_q;
  logic             hs;

  // Pop depends only on registered occupancy, keeping m_ready off the FIFO read path.
  assign fifo_rd_en = !rd_rst && !fifo_empty && !flush && (occ < 2'd2);
  assign hs         = m_valid && m_ready;

  stream_skid_buf #(.W(DATA_W)) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .flush     (flush),
    .push      (fifo_rd_en),
    .push_data (fifo_rd_data),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .occ       (occ)
  );

  always_comb begin
    beat_d       = beat_q;
    frame_done_d = 1'b0;
    if (flush) begin
      beat_d = '0;
    end else if (hs) begin
      if (beat_q == LAST_BEAT) begin
        beat_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign beat_cnt   = beat_q;
  assign frame_done = frame_done_q;
  assign m_last     = m_valid && (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised scoreboard bench for fifo_rd_stream with a queue-based FIFO source model.
module tb_fifo_rd_stream;

  localparam int FL = 4;

  logic        rd_clk, rd_rst;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty, fifo_rd_en, flush;
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_last, frame_done;
  logic [1:0]  beat_cnt;
  logic [1:0]  occ;

  fifo_rd_stream #(.DATA_W(16), .FRAME_LEN(FL)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .beat_cnt     (beat_cnt),
    .frame_done   (frame_done),
    .occ          (occ)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_chk = 0, n_pass = 0;
  logic [15:0] src_q[$];
  logic [15:0] sb_q[$];
  int  mdl_beat = 0;
  bit  mdl_done = 0;
  bit  pop_pend = 0;
  int  pops = 0, delivered = 0, frames = 0, lasts = 0, viol = 0;
  int  max_occ = 0;
  bit  toggle_en = 0, rand_ready = 0, gate = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic refresh_src();
    fifo_empty   = (src_q.size() == 0) || gate;
    fifo_rd_data = (src_q.size() != 0) ? src_q[0] : 16'hDEAD;
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge rd_clk);
    #1;
    if (pop_pend) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      pop_pend = 0;
    end
    gate = toggle_en ? ~gate : 1'b0;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    refresh_src();
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    src_q.delete();
    refresh_src();
    repeat (2) step();
    rd_rst = 1'b0;
  endtask

  // Monitor: outputs are stable mid-cycle; compare, then advance the model across the next edge.
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_valid", 32'(m_valid), 0);
      check("rst_occ", 32'(occ), 0);
      check("rst_beat", 32'(beat_cnt), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_last", 32'(m_last), 0);
      check("rst_data", 32'(m_data), 0);
      sb_q.delete();
      mdl_beat = 0;
      mdl_done = 0;
    end else begin
      check("rd_en", 32'(fifo_rd_en),
            32'(!fifo_empty && !flush && sb_q.size() < 2));
      check("occ", 32'(occ), sb_q.size());
      check("valid", 32'(m_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) check("data", 32'(m_data), 32'(sb_q[0]));
      check("beat_cnt", 32'(beat_cnt), mdl_beat);
      check("last", 32'(m_last), 32'(sb_q.size() != 0 && mdl_beat == FL - 1));
      check("frame_done", 32'(frame_done), 32'(mdl_done));
      if (fifo_rd_en && fifo_empty) viol++;
      if (int'(occ) > max_occ) max_occ = int'(occ);
      mdl_done = 0;
      if (flush) begin
        sb_q.delete();
        mdl_beat = 0;
      end else if (sb_q.size() != 0 && m_ready) begin
        void'(sb_q.pop_front());
        delivered++;
        if (m_last) lasts++;
        if (mdl_beat == FL - 1) begin
          mdl_beat = 0;
          mdl_done = 1;
          frames++;
        end else begin
          mdl_beat++;
        end
      end
      if (fifo_rd_en) begin
        sb_q.push_back(fifo_rd_data);
        pop_pend = 1;
        pops++;
      end
    end
  end

  initial begin
    int p0, d0, f0, l0, n;
    logic [15:0] w;
    rd_rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) step();
    rd_rst = 1'b0;

    // Back-to-back streaming of four words.
    for (int i = 1; i <= 4; i++) src_q.push_back(16'(i));
    m_ready = 1'b1; refresh_src();
    max_occ = 0; p0 = pops; d0 = delivered;
    repeat (8) step();
    check("p1_pops", pops - p0, 4);
    check("p1_beats", delivered - d0, 4);
    check("p1_max_occ", max_occ, 1);

    // Backpressure fills the buffer, then releases in order.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(16'h0010 + 16'(i));
    refresh_src(); p0 = pops;
    repeat (5) step();
    check("p2_pops", pops - p0, 2);
    check("p2_occ", 32'(occ), 2);
    check("p2_rd_en", 32'(fifo_rd_en), 0);
    check("p2_hold", 32'(m_data), 32'h10);
    m_ready = 1'b1; d0 = delivered;
    repeat (10) step();
    check("p2_beats", delivered - d0, 5);

    // Framing over ten beats.
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back(16'h0300 + 16'(i));
    refresh_src(); m_ready = 1'b1;
    d0 = delivered; f0 = frames; l0 = lasts;
    repeat (14) step();
    check("p3_beats", delivered - d0, 10);
    check("p3_frames", frames - f0, 2);
    check("p3_lasts", lasts - l0, 2);
    check("p3_beat_cnt", 32'(beat_cnt), 2);

    // Flush with a full buffer mid-frame.
    do_reset();
    src_q.push_back(16'h0100); refresh_src(); m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(16'h0200 + 16'(i));
    refresh_src();
    repeat (4) step();
    check("p4_occ_full", 32'(occ), 2);
    check("p4_beat_one", 32'(beat_cnt), 1);
    p0 = pops; flush = 1'b1;
    check("p4_flush_rd_en", 32'(fifo_rd_en), 0);
    step();
    flush = 1'b0;
    check("p4_occ", 32'(occ), 0);
    check("p4_valid", 32'(m_valid), 0);
    check("p4_beat", 32'(beat_cnt), 0);
    check("p4_no_pop", pops - p0, 0);
    w = src_q[0]; m_ready = 1'b1; n = 0;
    while (!m_valid && n < 10) begin step(); n++; end
    check("p4_seen", 32'(m_valid), 1);
    check("p4_first_word", 32'(m_data), 32'(w));
    check("p4_first_beat", 32'(beat_cnt), 0);
    repeat (6) step();
    src_q.push_back(16'h0400); refresh_src();
    flush = 1'b1;
    check("p4_gate_rd_en", 32'(fifo_rd_en), 0);
    step();
    flush = 1'b0;
    check("p4_gate_occ", 32'(occ), 0);
    repeat (4) step();

    // Asynchronous reset between edges.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(16'h0500 + 16'(i));
    refresh_src();
    repeat (4) step();
    #2 rd_rst = 1'b1;
    #1;
    check("p5_valid", 32'(m_valid), 0);
    check("p5_occ", 32'(occ), 0);
    check("p5_beat", 32'(beat_cnt), 0);
    check("p5_rd_en", 32'(fifo_rd_en), 0);
    repeat (2) step();
    check("p5_rd_en_held", 32'(fifo_rd_en), 0);
    rd_rst = 1'b0;

    // Toggling empty flag with random backpressure.
    do_reset();
    toggle_en = 1; rand_ready = 1; viol = 0;
    for (int i = 0; i < 1000; i++) src_q.push_back(16'($urandom));
    refresh_src();
    d0 = delivered; n = 0;
    while (delivered - d0 < 1000 && n < 8000) begin step(); n++; end
    check("p6_beats", delivered - d0, 1000);
    check("p6_src_drained", src_q.size(), 0);
    check("p6_empty_pop", viol, 0);
    toggle_en = 0; rand_ready = 0; m_ready = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
